// File: rtl/seg_scan_decoder.sv
// Recovers the four hex digits shown on a scanned, active-low 7-segment display by watching its
// anode and segment buses, and publishes each complete frame once all four positions are sampled.
module seg_scan_decoder #(
  parameter int unsigned SETTLE  = 16,
  parameter int unsigned TIMEOUT = 500000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] seg,
  input  logic [3:0] an,
  output logic [4:0] digit0,
  output logic [4:0] digit1,
  output logic [4:0] digit2,
  output logic [4:0] digit3,
  output logic       frame_valid,
  output logic       frame_err,
  output logic       scan_lost
);

  localparam int unsigned SW = $clog2(SETTLE + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] SettleLast = SW'(SETTLE - 1);
  localparam logic [TW-1:0] TimeoutMax = TW'(TIMEOUT);
  localparam logic [4:0] CodeOff = 5'd16;
  localparam logic [4:0] CodeBad = 5'd31;

  typedef enum logic [1:0] {StWait, StSettle, StHeld} state_e;

  logic [6:0]    r_seg_s1, r_seg_s2, r_seg_prev;
  logic [3:0]    r_an_s1, r_an_s2, r_an_prev;
  state_e        r_state, w_state_d;
  logic [SW-1:0] r_set_cnt, w_set_cnt_d;
  logic [TW-1:0] r_to_cnt, w_to_cnt_d;
  logic [3:0]    r_mask, w_mask_d;
  logic [4:0]    r_shadow [4];
  logic [4:0]    r_digit [4];
  logic          r_frame_valid, r_frame_err, r_scan_lost, w_scan_lost_d;
  logic          w_changed, w_an_valid, w_sample, w_publish, w_to_reach;
  logic [1:0]    w_an_idx;
  logic [4:0]    w_code;

  // Prev copies track the synchronized values one cycle back, for change detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg_s1   <= '1;
      r_seg_s2   <= '1;
      r_seg_prev <= '1;
      r_an_s1    <= '1;
      r_an_s2    <= '1;
      r_an_prev  <= '1;
    end else begin
      r_seg_s1   <= seg;
      r_seg_s2   <= r_seg_s1;
      r_seg_prev <= r_seg_s2;
      r_an_s1    <= an;
      r_an_s2    <= r_an_s1;
      r_an_prev  <= r_an_s2;
    end
  end

  assign w_changed = (r_seg_s2 != r_seg_prev) || (r_an_s2 != r_an_prev);

  always_comb begin
    w_an_valid = 1'b1;
    w_an_idx   = 2'd0;
    case (r_an_s2)
      4'b1110: w_an_idx = 2'd0;
      4'b1101: w_an_idx = 2'd1;
      4'b1011: w_an_idx = 2'd2;
      4'b0111: w_an_idx = 2'd3;
      default: w_an_valid = 1'b0;
    endcase
  end

  always_comb begin
    w_code = CodeBad;
    case (r_seg_s2)
      7'b0000001: w_code = 5'd0;
      7'b1001111: w_code = 5'd1;
      7'b0010010: w_code = 5'd2;
      7'b0000110: w_code = 5'd3;
      7'b1001100: w_code = 5'd4;
      7'b0100100: w_code = 5'd5;
      7'b0100000: w_code = 5'd6;
      7'b0001111: w_code = 5'd7;
      7'b0000000: w_code = 5'd8;
      7'b0000100: w_code = 5'd9;
      7'b0001000: w_code = 5'd10;
      7'b1100000: w_code = 5'd11;
      7'b0110001: w_code = 5'd12;
      7'b1000010: w_code = 5'd13;
      7'b0110000: w_code = 5'd14;
      7'b0111000: w_code = 5'd15;
      7'b1111111: w_code = 5'd16;
      7'b1111110: w_code = 5'd17;
      default:    w_code = CodeBad;
    endcase
  end

  always_comb begin
    w_state_d   = r_state;
    w_set_cnt_d = r_set_cnt;
    w_sample    = 1'b0;
    case (r_state)
      StWait: begin
        if (w_an_valid) begin
          w_state_d   = StSettle;
          w_set_cnt_d = '0;
        end
      end
      StSettle: begin
        if (!w_an_valid) begin
          w_state_d = StWait;
        end else if (w_changed) begin
          w_set_cnt_d = '0;
        end else if (r_set_cnt == SettleLast) begin
          w_sample  = 1'b1;
          w_state_d = StHeld;
        end else begin
          w_set_cnt_d = r_set_cnt + SW'(1);
        end
      end
      StHeld: begin
        if (w_changed) begin
          w_state_d   = w_an_valid ? StSettle : StWait;
          w_set_cnt_d = '0;
        end
      end
      default: w_state_d = StWait;
    endcase
  end

  // A sample landing on the publish or timeout cycle re-arms its bit after the clear.
  always_comb begin
    w_publish  = (r_mask == 4'hF);
    w_to_cnt_d = r_to_cnt;
    if (w_sample) begin
      w_to_cnt_d = '0;
    end else if (r_to_cnt != TimeoutMax) begin
      w_to_cnt_d = r_to_cnt + TW'(1);
    end
    w_to_reach    = !w_sample && (w_to_cnt_d == TimeoutMax);
    w_scan_lost_d = r_scan_lost;
    if (w_sample) begin
      w_scan_lost_d = 1'b0;
    end else if (w_to_reach) begin
      w_scan_lost_d = 1'b1;
    end
    w_mask_d = r_mask;
    if (w_publish || w_to_reach) begin
      w_mask_d = '0;
    end
    if (w_sample) begin
      w_mask_d[w_an_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= StWait;
      r_set_cnt     <= '0;
      r_to_cnt      <= '0;
      r_mask        <= '0;
      r_frame_valid <= 1'b0;
      r_frame_err   <= 1'b0;
      r_scan_lost   <= 1'b1;
      for (int i = 0; i < 4; i++) begin
        r_shadow[i] <= CodeOff;
        r_digit[i]  <= CodeOff;
      end
    end else begin
      r_state       <= w_state_d;
      r_set_cnt     <= w_set_cnt_d;
      r_to_cnt      <= w_to_cnt_d;
      r_mask        <= w_mask_d;
      r_scan_lost   <= w_scan_lost_d;
      r_frame_valid <= w_publish;
      if (w_sample) begin
        r_shadow[w_an_idx] <= w_code;
      end
      if (w_publish) begin
        r_frame_err <= (r_shadow[0] == CodeBad) || (r_shadow[1] == CodeBad) ||
                       (r_shadow[2] == CodeBad) || (r_shadow[3] == CodeBad);
        for (int i = 0; i < 4; i++) begin
          r_digit[i] <= r_shadow[i];
        end
      end
    end
  end

  assign digit0      = r_digit[0];
  assign digit1      = r_digit[1];
  assign digit2      = r_digit[2];
  assign digit3      = r_digit[3];
  assign frame_valid = r_frame_valid;
  assign frame_err   = r_frame_err;
  assign scan_lost   = r_scan_lost;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: directed scenarios plus random scan steps, checked
// against a frame-level model that tracks positions seen, latest codes and published frames.
module tb_seg_scan_decoder;

  localparam int unsigned Settle  = 16;
  localparam int unsigned Timeout = 2000;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] seg;
  logic [3:0] an;
  logic [4:0] digit0, digit1, digit2, digit3;
  logic       frame_valid, frame_err, scan_lost;
  logic [4:0] dig [4];

  seg_scan_decoder #(
    .SETTLE (Settle),
    .TIMEOUT(Timeout)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .seg        (seg),
    .an         (an),
    .digit0     (digit0),
    .digit1     (digit1),
    .digit2     (digit2),
    .digit3     (digit3),
    .frame_valid(frame_valid),
    .frame_err  (frame_err),
    .scan_lost  (scan_lost)
  );

  assign dig[0] = digit0;
  assign dig[1] = digit1;
  assign dig[2] = digit2;
  assign dig[3] = digit3;

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int fv_seen = 0;

  // Every high cycle counts, so a stretched pulse shows up as an extra frame.
  always @(negedge clk) if (frame_valid) fv_seen++;

  // Segment patterns indexed by the code they display.
  logic [6:0] seg_tab [18] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
    7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000, 7'b1111111, 7'b1111110
  };

  int m_shadow [4];
  int m_digit [4];
  int m_mask, m_frames, m_err, m_lost;

  function automatic int ref_decode(input logic [6:0] s);
    for (int i = 0; i < 18; i++) if (seg_tab[i] == s) return i;
    return 31;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 4; i++) begin
      m_shadow[i] = 16;
      m_digit[i]  = 16;
    end
    m_mask = 0;
    m_err  = 0;
    m_lost = 1;
  endfunction

  function automatic void model_sample(input int pos, input logic [6:0] s);
    m_shadow[pos] = ref_decode(s);
    m_mask       |= (1 << pos);
    m_lost        = 0;
    if (m_mask == 15) begin
      m_err = 0;
      for (int i = 0; i < 4; i++) begin
        m_digit[i] = m_shadow[i];
        if (m_shadow[i] == 31) m_err = 1;
      end
      m_frames++;
      m_mask = 0;
    end
  endfunction

  function automatic void model_timeout();
    m_mask = 0;
    m_lost = 1;
  endfunction

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    for (int i = 0; i < 4; i++) check_eq($sformatf("%s.digit%0d", tag, i), dig[i], m_digit[i]);
    check_eq({tag, ".frames"}, fv_seen, m_frames);
    check_eq({tag, ".frame_err"}, frame_err, m_err);
    check_eq({tag, ".scan_lost"}, scan_lost, m_lost);
  endtask

  // Show one position for hold cycles, then blank briefly as a real scanner would.
  task automatic drive_step(input int pos, input logic [6:0] s, input int hold);
    logic [3:0] a;
    a      = 4'hF;
    a[pos] = 1'b0;
    an     = a;
    seg    = s;
    repeat (hold) @(posedge clk);
    #1;
    an = 4'hF;
    repeat (4) @(posedge clk);
    #1;
    model_sample(pos, s);
  endtask

  task automatic hold_an(input logic [3:0] a, input int cycles);
    an = a;
    repeat (cycles) @(posedge clk);
    #1;
    an = 4'hF;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [6:0] s;
    rst = 1'b1;
    seg = '1;
    an  = '1;
    m_frames = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Basic scan showing 0123.
    drive_step(0, 7'b0000110, 1000);
    check_eq("scan.lost_after_first", scan_lost, 0);
    drive_step(1, 7'b0010010, 1000);
    drive_step(2, 7'b1001111, 1000);
    drive_step(3, 7'b0000001, 1000);
    check_eq("scan.d0", digit0, 3);
    check_eq("scan.d1", digit1, 2);
    check_eq("scan.d2", digit2, 1);
    check_eq("scan.d3", digit3, 0);
    check_eq("scan.frames", fv_seen, 1);
    check_outputs("scan");

    // Bouncing segments on position 0 must not be sampled until they stay put.
    drive_step(1, seg_tab[5], 40);
    drive_step(2, seg_tab[6], 40);
    drive_step(3, seg_tab[7], 40);
    an = 4'b1110;
    for (int k = 0; k < 25; k++) begin
      seg = (k % 2 == 0) ? seg_tab[8] : seg_tab[9];
      repeat (8) @(posedge clk);
      #1;
    end
    check_eq("glitch.no_frame", fv_seen, m_frames);
    drive_step(0, seg_tab[10], 40);
    check_eq("glitch.digit0", digit0, 10);
    check_outputs("glitch");

    // Unknown pattern publishes code 31, then a clean frame clears the error.
    drive_step(0, 7'b1010101, 40);
    drive_step(1, seg_tab[1], 40);
    drive_step(2, seg_tab[2], 40);
    drive_step(3, seg_tab[3], 40);
    check_eq("bad.digit0", digit0, 31);
    check_eq("bad.frame_err", frame_err, 1);
    drive_step(0, seg_tab[4], 40);
    drive_step(1, seg_tab[1], 40);
    drive_step(2, seg_tab[2], 40);
    drive_step(3, seg_tab[3], 40);
    check_eq("clean.frame_err", frame_err, 0);
    check_outputs("clean");

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 3) != 0) s = seg_tab[$urandom_range(0, 17)];
      else s = 7'($urandom);
      drive_step($urandom_range(0, 3), s, $urandom_range(30, 60));
      check_outputs($sformatf("rand%0d", n));
    end

    // Blank display past the timeout after a partial frame.
    drive_step(0, seg_tab[1], 40);
    drive_step(1, seg_tab[2], 40);
    hold_an(4'hF, Timeout + 50);
    model_timeout();
    check_eq("timeout.scan_lost", scan_lost, 1);
    check_outputs("timeout");
    drive_step(2, seg_tab[3], 40);
    drive_step(3, seg_tab[4], 40);
    check_outputs("timeout.partial");
    drive_step(0, seg_tab[5], 40);
    drive_step(1, seg_tab[6], 40);
    check_outputs("timeout.resume");

    // Two anodes low is never sampled and lets the timeout run out.
    drive_step(0, seg_tab[11], 40);
    seg = seg_tab[12];
    hold_an(4'b1100, Timeout + 50);
    model_timeout();
    check_eq("twolow.scan_lost", scan_lost, 1);
    check_outputs("twolow");
    drive_step(1, seg_tab[13], 40);
    drive_step(2, seg_tab[14], 40);
    drive_step(3, seg_tab[15], 40);
    check_outputs("twolow.resume");

    // Reset after three positions throws the partial frame away.
    drive_step(0, seg_tab[1], 40);
    drive_step(1, seg_tab[1], 40);
    drive_step(2, seg_tab[1], 40);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("midreset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    drive_step(3, seg_tab[1], 40);
    check_outputs("midreset.after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
